// File: rtl/wb_cyc_pkg.sv
// Shared types for the Wishbone cycle master: FSM state encoding, the
// latched request record and a counter-width helper.
package wb_cyc_pkg;

  // Widths of the latched request record. The master supports AW/DW up to
  // these values; narrower buses are zero-extended into the record.
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACTIVE     = 2'd1,
    RETRY_WAIT = 2'd2,
    DONE       = 2'd3
  } wb_cyc_state_t;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] addr;
    logic [WB_SW-1:0] sel;
    logic [WB_DW-1:0] data;
  } wb_req_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_cycle_master.sv
// Wishbone B4 upstream cycle generator for core load/store traffic.
// Accepts one request at a time, drives a registered classic cycle, owns the
// RTY retry policy and returns a one-cycle response pulse.
// Optional bus watchdog enabled by defining WB_CYC_TIMEOUT_EN.
module wb_cycle_master
  import wb_cyc_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW/8-1:0] req_sel,
  input  logic [DW-1:0]   req_data,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [DW-1:0]   rsp_data,
  output logic            CYC,
  output logic            STB,
  output logic            WE,
  output logic [AW-1:0]   ADR,
  output logic [DW/8-1:0] SEL,
  output logic [DW-1:0]   DAT_O,
  input  logic [DW-1:0]   DAT_I,
  input  logic            ACK,
  input  logic            ERR,
  input  logic            RTY
);

  localparam int RCW = cnt_w(MAX_RETRY + 1);
  localparam int GCW = cnt_w(RETRY_GAP);

  localparam logic [RCW-1:0] RETRY_LIMIT = RCW'(MAX_RETRY);
  localparam logic [GCW-1:0] GAP_LAST    = GCW'(RETRY_GAP - 1);

  wb_cyc_state_t  state;
  wb_req_t        bus_q;
  logic [RCW-1:0] retry_cnt;
  logic [GCW-1:0] gap_cnt;
  logic           cyc_q;

`ifdef WB_CYC_TIMEOUT_EN
  localparam int WCW = cnt_w(TIMEOUT);
  localparam logic [WCW-1:0] WD_LAST = WCW'(TIMEOUT - 1);
  logic [WCW-1:0] wd_cnt;
`endif

  // The latched request record is the bus address/data register itself, so
  // a re-issue after RTY drives exactly the same ADR/SEL/WE/DAT_O.
  assign WE    = bus_q.we;
  assign ADR   = AW'(bus_q.addr);
  assign SEL   = (DW/8)'(bus_q.sel);
  assign DAT_O = DW'(bus_q.data);
  assign CYC   = cyc_q;

  // Cycle FSM: request acceptance, bus cycle, retry gap and response pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      cyc_q     <= 1'b0;
      STB       <= 1'b0;
      bus_q     <= '0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
`ifdef WB_CYC_TIMEOUT_EN
      wd_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          if (req_valid) begin
            bus_q.we   <= req_we;
            bus_q.addr <= WB_AW'(req_addr);
            bus_q.sel  <= WB_SW'(req_sel);
            bus_q.data <= WB_DW'(req_data);
            cyc_q      <= 1'b1;
            STB        <= 1'b1;
            req_ready  <= 1'b0;
            state      <= ACTIVE;
`ifdef WB_CYC_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
          end
        end

        ACTIVE: begin
          // Termination priority ERR > RTY > ACK; a termination in the same
          // cycle as the watchdog expiry takes precedence over the timeout.
          if (ERR) begin
            cyc_q     <= 1'b0;
            STB       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            state     <= DONE;
          end else if (RTY) begin
            cyc_q <= 1'b0;
            STB   <= 1'b0;
            if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt <= retry_cnt + 1'b1;
              gap_cnt   <= '0;
              state     <= RETRY_WAIT;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= DONE;
            end
          end else if (ACK) begin
            cyc_q     <= 1'b0;
            STB       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= bus_q.we ? '0 : DAT_I;
            state     <= DONE;
          end
`ifdef WB_CYC_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            cyc_q     <= 1'b0;
            STB       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            state     <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        RETRY_WAIT: begin
          // Hold CYC low for RETRY_GAP cycles, then re-strobe the same request.
          if (gap_cnt == GAP_LAST) begin
            cyc_q <= 1'b1;
            STB   <= 1'b1;
            state <= ACTIVE;
`ifdef WB_CYC_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        DONE: begin
          // rsp_valid was high for this one cycle; reopen for the next request.
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          retry_cnt <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          cyc_q     <= 1'b0;
          STB       <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          retry_cnt <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
